rr_decode_arbiter: RTL and testbench

RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

---
 rtl/rr_decode_arbiter.sv | 94 +++++++++
 tb/tb_rr_decode_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - 8-way round-robin arbiter with one-hot grant decode
// Optional grant-hold timeout is built only when RR_ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] idx_q;
  logic [2:0] pick;
  logic [2:0] cand;
  logic       release_now;

  // Walk from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    pick = ptr;
    cand = ptr;
    for (int k = 7; k >= 0; k--) begin
      cand = ptr + 3'(k);
      if (req[cand]) pick = cand;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [4:0] LIMIT = 5'(TIMEOUT_CYCLES);

  logic [4:0] hold_cnt;
  logic       limit_hit;
  logic       timeout_q;

  assign limit_hit   = (state == GRANT) && (hold_cnt + 5'd1 == LIMIT);
  assign release_now = done || limit_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= 5'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= limit_hit && !done;
      if (state == IDLE) hold_cnt <= 5'd0;
      else               hold_cnt <= hold_cnt + 5'd1;
    end
  end

  assign timeout = timeout_q;
`else
  logic [4:0] unused_timeout_cfg;

  assign unused_timeout_cfg = 5'(TIMEOUT_CYCLES);
  assign release_now        = done;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      idx_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 8'd0) begin
            state <= GRANT;
            idx_q <= pick;
          end
        end
        GRANT: begin
          if (release_now) begin
            state <= IDLE;
            ptr   <= idx_q + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grant is a pure decode of registered state, so reset drops it immediately.
  assign busy    = (state == GRANT);
  assign gnt_idx = idx_q;
  assign gnt     = busy ? (8'd1 << idx_q) : 8'd0;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - self-checking bench for rr_decode_arbiter (honours RR_ARB_TIMEOUT_EN)
module tb_rr_decode_arbiter;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  rr_decode_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Reference model: who holds the grant, how long, and where the search starts.
  bit m_busy = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_hold = 0;
  bit m_to   = 0;

  always @(posedge clk) begin
    logic [7:0] r;
    logic d, rn;
    logic [7:0] exp_gnt;
    int ones;
    r = req; d = done; rn = rst_n;
    if (!rn) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else if (!m_busy) begin
      m_to = 0;
      if (r != 8'd0) begin
        for (int k = 7; k >= 0; k--)
          if (r[(m_ptr + k) % 8]) m_idx = (m_ptr + k) % 8;
        m_busy = 1;
        m_hold = 0;
      end
    end else begin
      m_hold++;
      m_to = 0;
      if (d) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
      end else if (TO_EN && m_hold == TO) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
        m_to   = 1;
      end
    end
    #1;
    exp_gnt = m_busy ? (8'd1 << m_idx) : 8'd0;
    ones = $countones(gnt);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("gnt_onehot0", 32'(ones <= 1), 32'd1);
    if (busy) chk("gnt_decode", 32'(gnt), 32'(8'd1 << gnt_idx));
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 8'd0; done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issue a single request, check the granted index, then release with done.
  task automatic grant_release(input logic [7:0] r, input int exp_idx, input string name);
    req = r;
    @(negedge clk);
    chk({name, "_busy"}, 32'(busy), 32'd1);
    chk({name, "_idx"}, 32'(gnt_idx), 32'(exp_idx));
    req = 8'd0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk({name, "_idle"}, 32'(gnt), 32'd0);
  endtask

  initial begin
    do_reset();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_idx", 32'(gnt_idx), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);

    // Single requester 2
    req = 8'b0000_0100;
    @(negedge clk);
    chk("r2_gnt", 32'(gnt), 32'h04);
    chk("r2_idx", 32'(gnt_idx), 32'd2);
    chk("r2_busy", 32'(busy), 32'd1);
    req = 8'd0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("r2_release", 32'(gnt), 32'd0);

    // All requesting: strict rotation with an idle gap between grants
    do_reset();
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("rot_idx", 32'(gnt_idx), 32'(i % 8));
      chk("rot_busy", 32'(busy), 32'd1);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      chk("rot_gap", 32'(gnt), 32'd0);
    end
    req = 8'd0;
    @(negedge clk);

    // Wrap-around: grant 6 leaves ptr at 7
    grant_release(8'b0100_0000, 6, "wrap6");
    grant_release(8'b1000_0001, 7, "wrap7");
    grant_release(8'b1000_0001, 0, "wrap0");

    // Releasing requester gets lowest priority next time
    grant_release(8'b0000_0011, 1, "lowpri1");
    grant_release(8'b0000_0011, 0, "lowpri0");

    // Async reset mid-grant on index 5
    req = 8'b0010_0000;
    @(negedge clk);
    chk("rst5_idx", 32'(gnt_idx), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("rst5_async_gnt", 32'(gnt), 32'd0);
    chk("rst5_async_busy", 32'(busy), 32'd0);
    @(negedge clk);
    req = 8'b0010_0001;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst5_after_idx", 32'(gnt_idx), 32'd0);
    req = 8'd0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;

    // Hold behaviour without done
    do_reset();
    req = 8'b0000_1000;
    @(negedge clk);
    req = 8'b0000_1001;
`ifdef RR_ARB_TIMEOUT_EN
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      chk("to_hold_busy", 32'(busy), 32'd1);
      chk("to_hold_pulse", 32'(timeout), 32'd0);
    end
    @(negedge clk);
    chk("to_release_busy", 32'(busy), 32'd0);
    chk("to_pulse", 32'(timeout), 32'd1);
    @(negedge clk);
    chk("to_pulse_end", 32'(timeout), 32'd0);
    chk("to_next_idx", 32'(gnt_idx), 32'd0);
    req = 8'd0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
`else
    repeat (40) @(negedge clk);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_idx", 32'(gnt_idx), 32'd3);
    chk("hold_timeout", 32'(timeout), 32'd0);
    req = 8'd0; done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("hold_release", 32'(busy), 32'd0);
`endif

    // Randomised traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      done  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; req = 8'd0; done = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
